// File: rtl/serial_addsub_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Digit counter width; never narrower than one bit so NDIG=1 still has a counter.
    function automatic int cnt_width(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/serial_addsub_add_slice.sv
// Combinational DIGIT-wide ripple slice; c_msb is the carry into the slice's top bit.
module add_slice #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [DIGIT:0] total;

    assign total = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
    assign s     = total[DIGIT-1:0];
    assign co    = total[DIGIT];
    // Carry into the top bit recovered from the top bit's sum equation.
    assign c_msb = s[DIGIT-1] ^ x[DIGIT-1] ^ y[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: one DIGIT-wide slice walks the operands LSB digit first.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = cnt_width(NDIG);

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [DIGIT-1:0] d_s;
    logic             d_co;
    logic             d_cmsb;
    logic             last;

    add_slice #(.DIGIT(DIGIT)) u_slice (
        .x    (op_a[DIGIT-1:0]),
        .y    (op_b[DIGIT-1:0]),
        .ci   (carry),
        .s    (d_s),
        .co   (d_co),
        .c_msb(d_cmsb)
    );

    // New digit enters at the top; after NDIG shifts the result is fully aligned.
    assign res_next = (res >> DIGIT) | (WIDTH'(d_s) << (WIDTH - DIGIT));
    assign last     = (cnt == CNT_W'(NDIG - 1));
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    op_a  <= op_a >> DIGIT;
                    op_b  <= op_b >> DIGIT;
                    carry <= d_co;
                    res   <= res_next;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        sum   <= res_next;
                        cout  <= d_co;
                        ovf   <= d_cmsb ^ d_co;
                        zero  <= (res_next == '0);
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Randomized and directed checks of serial_addsub (16/4 and 8/8) against an arithmetic model.
module tb_serial_addsub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, cin, sub;
    logic [15:0] a, b;
    logic        busy, done, cout, ovf, zero;
    logic [15:0] sum;

    logic        start8, cin8, sub8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, cout8, ovf8, zero8;
    logic [7:0]  sum8;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    serial_addsub #(.WIDTH(8), .DIGIT(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Plain-arithmetic reference: a + b + cin, or a - b as a + ~b + 1.
    function automatic void model(input int w, input logic [31:0] ta, input logic [31:0] tb,
                                  input logic tc, input logic ts, output logic [31:0] es,
                                  output logic ec, output logic eo, output logic ez);
        longint mask, bb, full;
        mask = (longint'(1) << w) - 1;
        bb   = ts ? (~longint'(tb) & mask) : longint'(tb);
        full = longint'(ta) + bb + (ts ? 1 : longint'(tc));
        es   = 32'(full & mask);
        ec   = full[w];
        eo   = (ta[w-1] == bb[w-1]) && (es[w-1] != ta[w-1]);
        ez   = (es == 0);
    endfunction

    task automatic check_res(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                             input logic tc, input logic ts);
        logic [31:0] es;
        logic ec, eo, ez;
        model(16, 32'(ta), 32'(tb), tc, ts, es, ec, eo, ez);
        chk({tag, ".sum"},  32'(sum),  es);
        chk({tag, ".cout"}, 32'(cout), 32'(ec));
        chk({tag, ".ovf"},  32'(ovf),  32'(eo));
        chk({tag, ".zero"}, 32'(zero), 32'(ez));
    endtask

    // One op on the 16-bit unit; optionally pulse start mid-RUN with other operands.
    task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                         input logic tc, input logic ts, input bit glitch);
        int lat, nbusy;
        @(negedge clk);
        a = ta; b = tb; cin = tc; sub = ts; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        lat = 0; nbusy = 0;
        while (!done && lat < 20) begin
            if (busy) nbusy++;
            start = glitch && (lat == 1);
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        chk({tag, ".lat"}, 32'(lat), 32'd4);
        chk({tag, ".busy_cycles"}, 32'(nbusy), 32'd4);
        check_res(tag, ta, tb, tc, ts);
        @(posedge clk); #1;
        chk({tag, ".done_pulse"}, 32'(done), 32'd0);
        chk({tag, ".idle"}, 32'(busy), 32'd0);
        check_res({tag, ".hold"}, ta, tb, tc, ts);
    endtask

    task automatic do_op8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                          input logic tc, input logic ts);
        int lat;
        logic [31:0] es;
        logic ec, eo, ez;
        @(negedge clk);
        a8 = ta; b8 = tb; cin8 = tc; sub8 = ts; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        lat = 0;
        while (!done8 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        model(8, 32'(ta), 32'(tb), tc, ts, es, ec, eo, ez);
        chk({tag, ".lat"},  32'(lat),   32'd1);
        chk({tag, ".sum"},  32'(sum8),  es);
        chk({tag, ".cout"}, 32'(cout8), 32'(ec));
        chk({tag, ".ovf"},  32'(ovf8),  32'(eo));
        chk({tag, ".zero"}, 32'(zero8), 32'(ez));
    endtask

    initial begin
        int lat;
        logic [15:0] hold_sum;
        start = 0; a = 0; b = 0; cin = 0; sub = 0;
        start8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy", 32'(busy), 0);
        chk("rst.done", 32'(done), 0);
        chk("rst.flags", {sum, cout, ovf, zero}, 0);
        chk("rst8.out", {busy8, done8, sum8, cout8, ovf8, zero8}, 0);
        @(negedge clk) rst_n = 1'b1;

        do_op("carry_chain", 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
        do_op("ovf_pos",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        do_op("wrap_zero",   16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0);
        do_op("sub_neg",     16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0);
        do_op("sub_eq",      16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0);
        do_op("sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
        do_op("glitch",      16'h0102, 16'h0304, 1'b0, 1'b0, 1'b1);

        // start held through DONE: second op accepted on the done edge
        @(negedge clk);
        a = 16'h4000; b = 16'h4000; cin = 0; sub = 0; start = 1'b1;
        @(posedge clk); #1;
        a = 16'h0010; b = 16'h0003; sub = 1'b1;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("b2b.lat1", 32'(lat), 32'd4);
        check_res("b2b.op1", 16'h4000, 16'h4000, 1'b0, 1'b0);
        hold_sum = sum;
        lat = 0;
        @(posedge clk); #1;
        start = 1'b0;
        lat++;
        while (!done && lat < 20) begin
            chk("b2b.stable", 32'(sum), 32'(hold_sum));
            @(posedge clk); #1;
            lat++;
        end
        chk("b2b.lat2", 32'(lat), 32'd5);
        check_res("b2b.op2", 16'h0010, 16'h0003, 1'b0, 1'b1);

        // reset two cycles after acceptance aborts the op with no done
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 0; sub = 0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort.out", {busy, done, sum, cout, ovf, zero}, 0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort.no_done", 32'(done), 0);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort.idle", {busy, done}, 0);
        do_op("after_rst", 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++)
            do_op("rand", 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

        do_op8("n1_ovf", 8'h80, 8'h80, 1'b0, 1'b0);
        do_op8("n1_sub", 8'h03, 8'h05, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++)
            do_op8("n1_rand", 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
